// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared processor definitions for the memory access
//               controller: default widths, FSM state encodings, requester
//               indices and the round-robin pick helper.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_ctrl_pkg;

    // Default datapath widths (MDR width and memory address width)
    localparam int c_data_w = 18;
    localparam int c_addr_w = 12;

    // Requester positions inside the two-bit request/grant vectors
    localparam int c_idx_if = 0;
    localparam int c_idx_ex = 1;

    // Controller states, explicitly encoded on three bits
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_XFER = 3'd2,
        ST_MEM  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // One-hot pick between the two requesters; on a tie the requester that
    // was not granted last wins, otherwise the lone request passes through.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_ex);
        logic [1:0] pick;
        pick = req;
        if (req == 2'b11) begin
            pick = last_ex ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arb
// Description : Two-input round-robin arbiter. Produces a one-hot grant
//               while the accept enable is high and remembers which side
//               won so the other side takes the next tie.
// Revision    : 1.0  initial release
// ============================================================================
module mem_rr_arb
    import mem_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last_ex;

    assign o_gnt = i_en ? rr_pick(i_req, r_last_ex) : 2'b00;

    // Track the last winner; reset favours the execute side on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ex <= 1'b0;
        end else if (|o_gnt) begin
            r_last_ex <= o_gnt[c_idx_ex];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Memory access controller arbitrating fetch and execute
//               requests, sequencing MDR and memory strobes for reads
//               (MEM -> XFER -> DONE) and writes (LOAD -> XFER -> MEM -> DONE).
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int ADDR_W  = c_addr_w,
    parameter int MEM_LAT = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_if,
    input  logic [ADDR_W-1:0] addr_if,
    input  logic              req_ex,
    input  logic              we_ex,
    input  logic [ADDR_W-1:0] addr_ex,
    input  logic [DATA_W-1:0] wdata_ex,
    output logic              gnt_if,
    output logic              gnt_ex,
    output logic              done_if,
    output logic              done_ex,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              wr_MDR_Mem,
    output logic              wr_MDR_Bus,
    output logic              re_MDR,
    output logic [DATA_W-1:0] MDRinBus,
    input  logic [DATA_W-1:0] MDRout
);

    // Remaining-cycle counter only needs to hold MEM_LAT-1
    localparam int c_cnt_w = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_we;
    logic                r_own_ex;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [1:0]          w_gnt;
    logic                w_arb_en;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic                w_wr_mem;
    logic                w_wr_bus;
    logic                w_re;
    logic                w_done;
    logic                w_rd_done;

    // Requests are only considered in IDLE and never while reset is held
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    mem_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({req_ex, req_if}),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    // State register plus the request latch, MEM cycle counter and read result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_own_ex <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (|w_gnt) begin
                r_own_ex <= w_gnt[c_idx_ex];
                r_we     <= w_gnt[c_idx_ex] & we_ex;
                r_addr   <= w_gnt[c_idx_ex] ? addr_ex : addr_if;
                r_data   <= wdata_ex;
            end
            if ((w_next_state == ST_MEM) && (r_state != ST_MEM)) begin
                r_cnt <= c_cnt_load;
            end else if ((r_state == ST_MEM) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_done) begin
                r_rdata <= MDRout;
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next_state = r_state;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_wr_mem     = 1'b0;
        w_wr_bus     = 1'b0;
        w_re         = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_next_state = (w_gnt[c_idx_ex] && we_ex) ? ST_LOAD : ST_MEM;
                end
            end
            ST_LOAD: begin
                w_wr_bus     = 1'b1;
                w_next_state = ST_XFER;
            end
            ST_XFER: begin
                w_re         = 1'b1;
                w_next_state = r_we ? ST_MEM : ST_DONE;
            end
            ST_MEM: begin
                if (r_we) begin
                    // Keep the MDR output enabled so memory sees stable data
                    w_mem_wr = 1'b1;
                    w_re     = 1'b1;
                end else begin
                    w_mem_rd = 1'b1;
                    w_wr_mem = (r_cnt == '0);
                end
                if (r_cnt == '0) begin
                    w_next_state = r_we ? ST_DONE : ST_XFER;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_rd_done = (r_state == ST_DONE) && !r_we;

    // Every output is forced low while reset is asserted
    assign gnt_if     = w_gnt[c_idx_if];
    assign gnt_ex     = w_gnt[c_idx_ex];
    assign done_if    = !rst && w_done && !r_own_ex;
    assign done_ex    = !rst && w_done && r_own_ex;
    assign mem_rd     = !rst && w_mem_rd;
    assign mem_wr     = !rst && w_mem_wr;
    assign wr_MDR_Mem = !rst && w_wr_mem;
    assign wr_MDR_Bus = !rst && w_wr_bus;
    assign re_MDR     = !rst && w_re;
    assign mem_addr   = rst ? '0 : r_addr;
    assign MDRinBus   = (!rst && w_wr_bus) ? r_data : '0;
    // MDRout is only valid in DONE, so pass it straight through there
    assign rdata      = rst ? '0 : (w_rd_done ? MDRout : r_rdata);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a memory/MDR
//               environment and a transaction-level timeline reference.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 18;
    localparam int AW = 12;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_if = 1'b0;
    logic [AW-1:0] addr_if = '0;
    logic          req_ex = 1'b0;
    logic          we_ex = 1'b0;
    logic [AW-1:0] addr_ex = '0;
    logic [DW-1:0] wdata_ex = '0;
    logic          gnt_if, gnt_ex, done_if, done_ex;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr, wr_MDR_Mem, wr_MDR_Bus, re_MDR;
    logic [DW-1:0] MDRinBus;
    wire  [DW-1:0] MDRout;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .req_if(req_if), .addr_if(addr_if),
        .req_ex(req_ex), .we_ex(we_ex), .addr_ex(addr_ex), .wdata_ex(wdata_ex),
        .gnt_if(gnt_if), .gnt_ex(gnt_ex), .done_if(done_if), .done_ex(done_ex),
        .rdata(rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wr_MDR_Mem(wr_MDR_Mem), .wr_MDR_Bus(wr_MDR_Bus), .re_MDR(re_MDR),
        .MDRinBus(MDRinBus), .MDRout(MDRout)
    );

    // Environment: memory array and a registered MDR with tri-state output
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    logic [DW-1:0] mdr_q = '0;
    logic          mdr_oe = 1'b0;
    assign MDRout = mdr_oe ? mdr_q : {DW{1'bz}};

    always @(posedge clk) begin
        if (wr_MDR_Mem)      mdr_q <= env_mem[mem_addr];
        else if (wr_MDR_Bus) mdr_q <= MDRinBus;
        mdr_oe <= re_MDR;
        if (mem_wr) env_mem[mem_addr] <= MDRout;
    end

    // Reference: memory contents as seen by completed transactions
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_busy, m_ex, m_we, m_last_ex;
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int dut_gnts[$];
    int n_done_dut = 0;
    bit saw_gif, saw_gex, hold_both = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_check();
        logic [8:0] got_ctl, exp_ctl;
        bit e_gif, e_gex, e_dif, e_dex, e_rd, e_wr, e_wmm, e_wmb, e_re, pick_ex;
        got_ctl = {gnt_if, gnt_ex, done_if, done_ex, mem_rd, mem_wr, wr_MDR_Mem, wr_MDR_Bus, re_MDR};
        check("mdr_excl", 32'($countones({wr_MDR_Mem, wr_MDR_Bus, re_MDR}) <= 1), 32'd1);
        check("mem_excl", 32'(mem_rd & mem_wr), 32'd0);
        if (rst) begin
            check("rst_ctl", 32'(got_ctl), 32'd0);
            check("rst_rdata", 32'(rdata), 32'd0);
            check("rst_addr", 32'(mem_addr), 32'd0);
            check("rst_bus", 32'(MDRinBus), 32'd0);
            m_busy = 0; m_last_ex = 0; m_rdata = '0;
            return;
        end
        {e_gif, e_gex, e_dif, e_dex, e_rd, e_wr, e_wmm, e_wmb, e_re} = '0;
        if (!m_busy) begin
            if (req_if || req_ex) begin
                pick_ex = (req_if && req_ex) ? !m_last_ex : req_ex;
                e_gex = pick_ex; e_gif = !pick_ex;
                m_busy = 1; m_k = 0; m_ex = pick_ex; m_last_ex = pick_ex;
                m_we   = pick_ex && we_ex;
                m_addr = pick_ex ? addr_ex : addr_if;
                m_data = wdata_ex;
            end
        end else begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (!m_we) begin
                e_rd  = (m_k >= 1) && (m_k <= L);
                e_wmm = (m_k == L);
                e_re  = (m_k == L + 1);
                if (m_k == L + 2) begin
                    e_dif = !m_ex; e_dex = m_ex;
                    m_rdata = ref_mem[m_addr];
                    m_busy = 0;
                end
            end else begin
                e_wmb = (m_k == 1);
                e_re  = (m_k >= 2) && (m_k <= L + 2);
                e_wr  = (m_k >= 3) && (m_k <= L + 2);
                if (m_k == 1) check("mdr_in_bus", 32'(MDRinBus), 32'(m_data));
                if (m_k == L + 3) begin
                    e_dex = 1;
                    ref_mem[m_addr] = m_data;
                    m_busy = 0;
                end
            end
        end
        exp_ctl = {e_gif, e_gex, e_dif, e_dex, e_rd, e_wr, e_wmm, e_wmb, e_re};
        check("ctl", 32'(got_ctl), 32'(exp_ctl));
        check("rdata", 32'(rdata), 32'(m_rdata));
        if (m_busy) m_k++;
    endtask

    // One clock: check at the falling edge, then drive after the rising edge
    task automatic step();
        @(negedge clk);
        saw_gif = gnt_if; saw_gex = gnt_ex;
        if (gnt_ex) dut_gnts.push_back(1);
        if (gnt_if) dut_gnts.push_back(0);
        if (done_if || done_ex) n_done_dut++;
        model_check();
        @(posedge clk); #1;
        if (hold_both) begin
            if (dut_gnts.size() >= 4) begin
                req_if = 0; req_ex = 0; hold_both = 0;
            end
        end else begin
            if (saw_gif) req_if = 0;
            if (saw_gex) req_ex = 0;
        end
    endtask

    initial begin
        int d0, n0, steps;
        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i] = DW'(i * 37 + 11);
            ref_mem[i] = DW'(i * 37 + 11);
        end
        env_mem[5] = 18'h2A5A5;
        ref_mem[5] = 18'h2A5A5;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        rst = 0;

        // Fetch read of 0x005
        req_if = 1; addr_if = 12'h005;
        for (int i = 0; i < L + 4; i++) step();
        check("if_rd_value", 32'(rdata), 32'h2A5A5);

        // Execute write of 0x3FFFF to 0x010
        req_ex = 1; we_ex = 1; addr_ex = 12'h010; wdata_ex = 18'h3FFFF;
        for (int i = 0; i < L + 5; i++) step();
        check("wr_keeps_rdata", 32'(rdata), 32'h2A5A5);

        // Both requests held from reset: EX, IF, EX, IF
        rst = 1; step(); rst = 0;
        dut_gnts.delete(); n_done_dut = 0;
        req_if = 1; addr_if = 12'h005; req_ex = 1; we_ex = 0; addr_ex = 12'h010;
        hold_both = 1;
        steps = 0;
        while (hold_both && steps < 60) begin step(); steps++; end
        req_if = 0; req_ex = 0; hold_both = 0;
        for (int i = 0; i < L + 5; i++) step();
        check("rr_count", 32'(dut_gnts.size()), 32'd4);
        if (dut_gnts.size() >= 4) begin
            check("rr_g0", 32'(dut_gnts[0]), 32'd1);
            check("rr_g1", 32'(dut_gnts[1]), 32'd0);
            check("rr_g2", 32'(dut_gnts[2]), 32'd1);
            check("rr_g3", 32'(dut_gnts[3]), 32'd0);
        end
        check("rr_dones", 32'(n_done_dut), 32'(dut_gnts.size()));

        // Reset at c3 of an execute write
        req_ex = 1; we_ex = 1; addr_ex = 12'h020; wdata_ex = 18'h12345;
        d0 = n_done_dut;
        step(); step(); step();
        rst = 1; step(); rst = 0;
        req_if = 1; addr_if = 12'h021; req_ex = 1; we_ex = 0; addr_ex = 12'h020;
        n0 = dut_gnts.size();
        step();
        check("abort_no_done", 32'(n_done_dut), 32'(d0));
        check("abort_tie_cnt", 32'(dut_gnts.size()), 32'(n0 + 1));
        if (dut_gnts.size() == n0 + 1) check("abort_tie_ex", 32'(dut_gnts[n0]), 32'd1);
        for (int i = 0; i < 20; i++) step();

        // Randomized mixed traffic
        for (int c = 0; c < 3000; c++) begin
            if (!req_if && $urandom_range(0, 2) == 0) begin
                req_if = 1; addr_if = AW'($urandom_range(0, 15));
            end
            if (!req_ex && $urandom_range(0, 2) == 0) begin
                req_ex = 1; we_ex = 1'($urandom_range(0, 1));
                addr_ex = AW'($urandom_range(0, 15)); wdata_ex = DW'($urandom());
            end
            step();
        end
        req_if = 0; req_ex = 0;
        for (int i = 0; i < 20; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
